// File: rtl/inverse_permute_module.sv
// rtl/inverse_permute_module.sv - bit-serial inverse pi permutation of one 25-bit slice
// Output bit (x,y) receives input bit (y, (2x+3y) mod 5); one bit per RUN cycle.
module inverse_permute_module #(
  parameter int size    = 5,
  parameter int memsize = 25,
  parameter int laneLen = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               initDecode,
  input  logic               start,
  input  logic [memsize-1:0] sliceIn,
  output logic               busy,
  output logic               done,
  output logic [memsize-1:0] sliceOut,
  output logic [5:0]         sliceCnt,
  output logic               lastSlice
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [2:0]         x, y, t, tb;
  logic [memsize-1:0] src_reg, work_reg, work_next;
  logic [4:0]         dst_idx, src_idx;
  logic [2:0]         t_plus2, t_step, tb_plus3, tb_step;
  logic               last_bit;

  // 5*n is formed as (n<<2)+n so no multiplier is needed.
  always_comb begin
    dst_idx   = {y, 2'b00} + {2'b00, y} + {2'b00, x};
    src_idx   = {t, 2'b00} + {2'b00, t} + {2'b00, y};
    work_next = work_reg;
    work_next[dst_idx] = src_reg[src_idx];
    t_plus2   = t + 3'd2;
    t_step    = (t_plus2 >= 3'd5) ? t_plus2 - 3'd5 : t_plus2;
    tb_plus3  = tb + 3'd3;
    tb_step   = (tb_plus3 >= 3'd5) ? tb_plus3 - 3'd5 : tb_plus3;
    last_bit  = (x == 3'(size - 1)) && (y == 3'(size - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      t         <= '0;
      tb        <= '0;
      src_reg   <= '0;
      work_reg  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sliceOut  <= '0;
      sliceCnt  <= '0;
      lastSlice <= 1'b0;
    end else if (initDecode) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      lastSlice <= 1'b0;
      sliceCnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done      <= 1'b0;
          lastSlice <= 1'b0;
          if (start) begin
            src_reg <= sliceIn;
            x       <= '0;
            y       <= '0;
            t       <= '0;
            tb      <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          work_reg <= work_next;
          if (last_bit) begin
            sliceOut  <= work_next;
            done      <= 1'b1;
            lastSlice <= (sliceCnt == 6'(laneLen - 1));
            sliceCnt  <= (sliceCnt == 6'(laneLen - 1)) ? 6'd0 : sliceCnt + 6'd1;
            state     <= DONE;
          end else if (x == 3'(size - 1)) begin
            // Row wrap: t restarts at 3y mod 5 for the new row.
            x  <= '0;
            y  <= y + 3'd1;
            tb <= tb_step;
            t  <= tb_step;
          end else begin
            x <= x + 3'd1;
            t <= t_step;
          end
        end
        DONE: begin
          done      <= 1'b0;
          lastSlice <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
